// File: rtl/lc3b_instr_encoder_pkg.sv
// Shared types for the LC-3b instruction encoder: opcodes, request and FIFO entry
// structs, plus the immediate range helpers used by the field packer.
package lc3b_instr_encoder_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LDB  = 4'b0010,
    OP_STB  = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_SHF  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } lc3b_opcode_e;

  typedef struct packed {
    lc3b_opcode_e opcode;
    logic [2:0]   dr;
    logic [2:0]   sr1;
    logic [2:0]   sr2;
    logic         imm_sel;
    logic [1:0]   shf;
    logic [15:0]  imm;
  } lc3b_enc_req_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] addr;
    logic        err;
  } lc3b_enc_entry_t;

  // Signed fit in n bits: everything from bit n-1 upward must be a copy of the sign.
  function automatic logic fits_signed(input logic [15:0] imm, input int unsigned n);
    logic [15:0] t;
    t = $signed(imm) >>> (n - 1);
    return (t == 16'h0000) || (t == 16'hFFFF);
  endfunction

  function automatic logic fits_unsigned(input logic [15:0] imm, input int unsigned n);
    return (imm >> n) == 16'h0000;
  endfunction

endpackage

// File: rtl/lc3b_instr_encoder_fields.sv
// Combinational packer: turns a decoded-form request into a 16-bit LC-3b word
// and flags immediates that are out of range or not halfword aligned.
module lc3b_encode_fields
  import lc3b_instr_encoder_pkg::*;
(
  input  lc3b_enc_req_t req,
  output logic [15:0]   instr,
  output logic          err
);

  logic [15:0] word;
  logic        bad;

  // Scaled offsets drop imm[0]; alignment is checked alongside the range.
  always_comb begin
    word = {req.opcode, 12'h000};
    bad  = 1'b0;
    case (req.opcode)
      OP_ADD, OP_AND: begin
        if (req.imm_sel) begin
          word[11:0] = {req.dr, req.sr1, 1'b1, req.imm[4:0]};
          bad        = !fits_signed(req.imm, 5);
        end else begin
          word[11:0] = {req.dr, req.sr1, 3'b000, req.sr2};
        end
      end
      OP_BR, OP_LEA: begin
        word[11:0] = {req.dr, req.imm[9:1]};
        bad        = !fits_signed(req.imm, 10) || req.imm[0];
      end
      OP_JSR: begin
        if (req.imm_sel) begin
          word[11:0] = {1'b1, req.imm[11:1]};
          bad        = !fits_signed(req.imm, 12) || req.imm[0];
        end else begin
          word[11:0] = {3'b000, req.sr1, 6'h00};
        end
      end
      OP_LDR, OP_STR, OP_LDI, OP_STI: begin
        word[11:0] = {req.dr, req.sr1, req.imm[6:1]};
        bad        = !fits_signed(req.imm, 7) || req.imm[0];
      end
      OP_LDB, OP_STB: begin
        word[11:0] = {req.dr, req.sr1, req.imm[5:0]};
        bad        = !fits_signed(req.imm, 6);
      end
      OP_TRAP: begin
        word[11:0] = {4'h0, req.imm[8:1]};
        bad        = !fits_unsigned(req.imm, 9) || req.imm[0];
      end
      OP_SHF: begin
        word[11:0] = {req.dr, req.sr1, req.shf, req.imm[3:0]};
        bad        = !fits_unsigned(req.imm, 4);
      end
      OP_NOT:  word[11:0] = {req.dr, req.sr1, 6'h3F};
      OP_JMP:  word[11:0] = {3'b000, req.sr1, 6'h00};
      default: word[11:0] = 12'h000;
    endcase
    instr = bad ? 16'h0000 : word;
    err   = bad;
  end

endmodule

// File: rtl/lc3b_instr_encoder.sv
// LC-3b instruction encoder: valid/ready request in, encoded word tagged with its
// memory address out through a 2-entry FIFO, plus accept/error statistics.
module lc3b_instr_encoder
  import lc3b_instr_encoder_pkg::*;
#(
  parameter logic [15:0] RESET_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_opcode,
  input  logic [2:0]  in_dr,
  input  logic [2:0]  in_sr1,
  input  logic [2:0]  in_sr2,
  input  logic        in_imm_sel,
  input  logic [1:0]  in_shf,
  input  logic [15:0] in_imm,
  input  logic        addr_load,
  input  logic [15:0] addr_base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [15:0] out_addr,
  output logic        out_err,
  output logic [15:0] enc_cnt,
  output logic [7:0]  err_cnt
);

  lc3b_enc_req_t   req;
  lc3b_enc_entry_t head, tail, new_entry;
  logic [15:0]     enc_instr, addr_q, tag;
  logic            enc_err, ready_q, accept, pop;
  logic [1:0]      count, next_count;

  assign req = '{opcode: lc3b_opcode_e'(in_opcode), dr: in_dr, sr1: in_sr1, sr2: in_sr2,
                 imm_sel: in_imm_sel, shf: in_shf, imm: in_imm};

  lc3b_encode_fields u_fields (
    .req   (req),
    .instr (enc_instr),
    .err   (enc_err)
  );

  assign accept    = in_valid && ready_q;
  assign pop       = (count != 2'd0) && out_ready;
  assign tag       = addr_load ? addr_base : addr_q;
  assign new_entry = '{instr: enc_instr, addr: tag, err: enc_err};

  always_comb begin
    next_count = count;
    if (accept && !pop)      next_count = count + 2'd1;
    else if (!accept && pop) next_count = count - 2'd1;
  end

  // head is the output register; tail only holds the second entry when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= 2'd0;
      ready_q <= 1'b1;
      addr_q  <= RESET_ADDR;
      enc_cnt <= 16'h0000;
      err_cnt <= 8'h00;
    end else begin
      count   <= next_count;
      ready_q <= (next_count != 2'd2);
      case ({accept, pop})
        2'b10: begin
          if (count == 2'd0) head <= new_entry;
          else               tail <= new_entry;
        end
        2'b01: head <= (count == 2'd2) ? tail : '0;
        2'b11: begin
          if (count == 2'd1) begin
            head <= new_entry;
          end else begin
            head <= tail;
            tail <= new_entry;
          end
        end
        default: ;
      endcase
      if (addr_load)   addr_q <= accept ? addr_base + 16'd2 : addr_base;
      else if (accept) addr_q <= addr_q + 16'd2;
      if (accept) enc_cnt <= enc_cnt + 16'd1;
      if (accept && enc_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (count != 2'd0);
  assign out_instr = head.instr;
  assign out_addr  = head.addr;
  assign out_err   = head.err;

endmodule

// File: tb/tb_lc3b_instr_encoder.sv
// Testbench for lc3b_instr_encoder: directed scenarios plus a randomized run
// scored against an arithmetic encoding model and a queue-based FIFO model.
module tb_lc3b_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, in_imm_sel, addr_load, out_valid, out_ready, out_err;
  logic [3:0]  in_opcode;
  logic [2:0]  in_dr, in_sr1, in_sr2;
  logic [1:0]  in_shf;
  logic [15:0] in_imm, addr_base, out_instr, out_addr, enc_cnt;
  logic [7:0]  err_cnt;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] addr;
    logic        err;
  } exp_t;

  always #5 clk = ~clk;

  lc3b_instr_encoder #(.RESET_ADDR(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_dr(in_dr),
    .in_sr1(in_sr1), .in_sr2(in_sr2), .in_imm_sel(in_imm_sel), .in_shf(in_shf),
    .in_imm(in_imm), .addr_load(addr_load), .addr_base(addr_base),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .enc_cnt(enc_cnt), .err_cnt(err_cnt)
  );

  // Reference encoding from the field rules, using signed integer offsets; returns {err, instr}.
  function automatic logic [16:0] ref_encode(input int op, input int dr, input int sr1,
      input int sr2, input int sel, input int shf, input logic [15:0] imm);
    int s, u, w;
    bit ok;
    s  = int'($signed(imm));
    u  = int'(imm);
    w  = op * 4096;
    ok = 1;
    case (op)
      1, 5: if (sel != 0) begin
              ok = (s >= -16) && (s <= 15);
              w += dr * 512 + sr1 * 64 + 32 + (s & 31);
            end else w += dr * 512 + sr1 * 64 + sr2;
      0, 14: begin
               ok = (s >= -512) && (s <= 510) && (s % 2 == 0);
               w += dr * 512 + ((s / 2) & 511);
             end
      4: if (sel != 0) begin
           ok = (s >= -2048) && (s <= 2046) && (s % 2 == 0);
           w += 2048 + ((s / 2) & 2047);
         end else w += sr1 * 64;
      6, 7, 10, 11: begin
                      ok = (s >= -64) && (s <= 62) && (s % 2 == 0);
                      w += dr * 512 + sr1 * 64 + ((s / 2) & 63);
                    end
      2, 3: begin
              ok = (s >= -32) && (s <= 31);
              w += dr * 512 + sr1 * 64 + (s & 63);
            end
      15: begin
            ok = (u <= 510) && (u % 2 == 0);
            w += u / 2;
          end
      13: begin
            ok = (u <= 15);
            w += dr * 512 + sr1 * 64 + shf * 16 + u;
          end
      9:  w += dr * 512 + sr1 * 64 + 63;
      12: w += sr1 * 64;
      default: ;
    endcase
    if (!ok) return {1'b1, 16'h0000};
    return {1'b0, 16'(w)};
  endfunction

  task automatic set_req(input int op, input int dr, input int sr1, input int sr2,
                         input int sel, input int shf, input logic [15:0] imm);
    in_opcode  = 4'(op);
    in_dr      = 3'(dr);
    in_sr1     = 3'(sr1);
    in_sr2     = 3'(sr2);
    in_imm_sel = 1'(sel);
    in_shf     = 2'(shf);
    in_imm     = imm;
  endtask

  // One-cycle request, then idle; ends on the negedge after the accept edge.
  task automatic send(input int op, input int dr, input int sr1, input int sr2,
                      input int sel, input int shf, input logic [15:0] imm);
    @(negedge clk);
    set_req(op, dr, sr1, sr2, sel, shf, imm);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    addr_load = 1'b0;
    addr_base = 16'h0000;
    out_ready = 1'b1;
    set_req(0, 0, 0, 0, 0, 0, 16'h0000);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++;
    if ({out_valid, in_ready, out_instr, out_addr, out_err} !== {1'b0, 1'b1, 16'h0, 16'h0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got valid=%b ready=%b instr=%h addr=%h err=%b, want 0 1 0000 0000 0",
               out_valid, in_ready, out_instr, out_addr, out_err);
    end
    vectors++;
    if ({enc_cnt, err_cnt} !== 24'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_counters: got enc=%h err=%h, want 0000 00", enc_cnt, err_cnt);
    end
  endtask

  task automatic test_encode();
    do_reset();
    send(1, 1, 2, 0, 1, 0, 16'hFFFD);
    vectors++;
    if ({out_valid, out_instr, out_addr, out_err} !== {1'b1, 16'h12BD, 16'h0000, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL add_imm: got v=%b %h @%h err=%b, want 1 12bd @0000 0", out_valid, out_instr, out_addr, out_err);
    end
    do_reset();
    send(0, 7, 0, 0, 0, 0, 16'hFFFC);
    vectors++;
    if ({out_instr, out_addr, out_err} !== {16'h0FFE, 16'h0000, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL br: got %h @%h err=%b, want 0ffe @0000 0", out_instr, out_addr, out_err);
    end
    send(15, 0, 0, 0, 0, 0, 16'h0046);
    vectors++;
    if ({out_instr, out_addr, out_err} !== {16'hF023, 16'h0002, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL trap: got %h @%h err=%b, want f023 @0002 0", out_instr, out_addr, out_err);
    end
    send(6, 1, 2, 0, 0, 0, 16'h0005);
    vectors++;
    if ({out_instr, out_err, err_cnt} !== {16'h0000, 1'b1, 8'd1}) begin
      miscompares++;
      $display("[TB] FAIL ldr_odd: got %h err=%b cnt=%0d, want 0000 1 1", out_instr, out_err, err_cnt);
    end
    send(1, 1, 2, 0, 1, 0, 16'h0010);
    vectors++;
    if ({out_instr, out_err, err_cnt, enc_cnt} !== {16'h0000, 1'b1, 8'd2, 16'd4}) begin
      miscompares++;
      $display("[TB] FAIL add_range: got %h err=%b cnt=%0d enc=%0d, want 0000 1 2 4", out_instr, out_err, err_cnt, enc_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    @(negedge clk);
    set_req(1, 1, 2, 3, 0, 0, 16'h0);
    in_valid = 1'b1;
    @(negedge clk);
    set_req(9, 4, 5, 0, 0, 0, 16'h0);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_ready: got %b, want 0", in_ready);
    end
    set_req(12, 0, 7, 0, 0, 0, 16'h0);
    @(negedge clk);
    vectors++;
    if ({in_ready, out_instr, out_addr} !== {1'b0, 16'h1283, 16'h0000}) begin
      miscompares++;
      $display("[TB] FAIL hold_head: got rdy=%b %h @%h, want 0 1283 @0000", in_ready, out_instr, out_addr);
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({in_ready, out_instr, out_addr} !== {1'b1, 16'h997F, 16'h0002}) begin
      miscompares++;
      $display("[TB] FAIL second_pop: got rdy=%b %h @%h, want 1 997f @0002", in_ready, out_instr, out_addr);
    end
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if ({out_valid, out_instr, out_addr, enc_cnt} !== {1'b1, 16'hC1C0, 16'h0004, 16'd3}) begin
      miscompares++;
      $display("[TB] FAIL third_entry: got v=%b %h @%h enc=%0d, want 1 c1c0 @0004 3", out_valid, out_instr, out_addr, enc_cnt);
    end
  endtask

  task automatic test_addr_load();
    do_reset();
    @(negedge clk);
    set_req(12, 0, 3, 0, 0, 0, 16'h0);
    addr_load = 1'b1;
    addr_base = 16'hFFFE;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    addr_load = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_addr !== 16'hFFFE) begin
      miscompares++;
      $display("[TB] FAIL load_tag: got %h, want fffe", out_addr);
    end
    send(9, 0, 0, 0, 0, 0, 16'h0);
    vectors++;
    if (out_addr !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL load_wrap: got %h, want 0000", out_addr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    send(9, 1, 1, 0, 0, 0, 16'h0);
    send(9, 2, 2, 0, 0, 0, 16'h0);
    vectors++;
    if ({out_valid, in_ready, enc_cnt} !== {1'b1, 1'b0, 16'd2}) begin
      miscompares++;
      $display("[TB] FAIL pre_reset: got v=%b rdy=%b enc=%0d, want 1 0 2", out_valid, in_ready, enc_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, enc_cnt, out_instr} !== {1'b0, 16'd0, 16'h0}) begin
      miscompares++;
      $display("[TB] FAIL async_clear: got v=%b enc=%0d instr=%h, want 0 0 0000", out_valid, enc_cnt, out_instr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL post_reset_ready: got %b, want 1", in_ready);
    end
  endtask

  task automatic test_random();
    exp_t        q[$];
    exp_t        e;
    logic [16:0] r;
    logic [15:0] m_addr, m_tag, imm;
    int          m_enc, m_err, op, dr, sr1, sr2, sel, shf;
    bit          m_ready, acc, pp;
    do_reset();
    m_addr = 16'h0000; m_enc = 0; m_err = 0; m_ready = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      vectors++;
      if ({out_valid, in_ready} !== {q.size() != 0, m_ready}) begin
        miscompares++;
        $display("[TB] FAIL rnd_flags cyc %0d: got v=%b rdy=%b, want %b %b", cyc, out_valid, in_ready, q.size() != 0, m_ready);
      end
      if (q.size() != 0) begin
        vectors++;
        if ({out_instr, out_addr, out_err} !== {q[0].instr, q[0].addr, q[0].err}) begin
          miscompares++;
          $display("[TB] FAIL rnd_head cyc %0d: got %h @%h err=%b, want %h @%h err=%b",
                   cyc, out_instr, out_addr, out_err, q[0].instr, q[0].addr, q[0].err);
        end
      end
      vectors++;
      if ({enc_cnt, err_cnt} !== {16'(m_enc), 8'(m_err)}) begin
        miscompares++;
        $display("[TB] FAIL rnd_counts cyc %0d: got enc=%0d err=%0d, want %0d %0d", cyc, enc_cnt, err_cnt, m_enc, m_err);
      end
      op = $urandom_range(0, 15); dr = $urandom_range(0, 7); sr1 = $urandom_range(0, 7);
      sr2 = $urandom_range(0, 7); sel = $urandom_range(0, 1); shf = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0:       imm = 16'($urandom_range(0, 40) - 20);
        1:       imm = 16'($urandom_range(0, 2200) - 1100);
        2:       imm = 16'($urandom);
        default: imm = 16'($urandom_range(0, 520));
      endcase
      set_req(op, dr, sr1, sr2, sel, shf, imm);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      addr_load = ($urandom_range(0, 15) == 0);
      addr_base = 16'($urandom) & 16'hFFFE;
      acc   = in_valid && m_ready;
      pp    = (q.size() != 0) && out_ready;
      m_tag = addr_load ? addr_base : m_addr;
      r     = ref_encode(op, dr, sr1, sr2, sel, shf, imm);
      @(posedge clk);
      if (pp) void'(q.pop_front());
      if (acc) begin
        e.instr = r[15:0]; e.addr = m_tag; e.err = r[16];
        q.push_back(e);
        m_enc = (m_enc + 1) % 65536;
        if (r[16] && m_err < 255) m_err++;
      end
      if (addr_load || acc) m_addr = m_tag + (acc ? 16'd2 : 16'd0);
      m_ready = (q.size() < 2);
    end
    in_valid  = 1'b0;
    addr_load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_encode();
    test_back_to_back();
    test_addr_load();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lc3b_instr_encoder.md
# lc3b_instr_encoder

Packs LC-3b instruction fields and a decoded-form immediate back into a 16-bit instruction word. It is the inverse of the datapath's immediate decoder and is used by the on-chip program loader and self-test sequencer to write encoded instructions into instruction memory. Requests arrive over a valid/ready handshake. Encoded words leave through a 2-entry output FIFO, each tagged with its target address and a range/alignment error flag.

## Interface
- RESET_ADDR, 16'h0000, value of the address counter after reset
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready at clk edge
- in_opcode  in  4  lc3b_opcode
- in_dr  in  3  DR / SR (stores) / nzp (BR)
- in_sr1  in  3  SR1 / BaseR
- in_sr2  in  3  SR2 (register-mode ADD/AND)
- in_imm_sel  in  1  ADD/AND: immediate mode; JSR: 1 = JSR, 0 = JSRR
- in_shf  in  2  SHF bits [5:4] (D, A)
- in_imm  in  16  immediate in decoded form (sign-extended, byte-scaled where the decoder shifts)
- addr_load  in  1  load address counter from addr_base
- addr_base  in  16  new address counter value
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer pops head when out_valid && out_ready
- out_instr  out  16  encoded word at head
- out_addr  out  16  memory address for head word
- out_err  out  1  head request was out of range or misaligned
- enc_cnt  out  16  accepted requests, wraps
- err_cnt  out  8  erroneous requests, saturates at 8'hFF

## Operation
- Encoding, fields [15:12] = opcode:
  - ADD/AND, imm mode: [11:9]=dr, [8:6]=sr1, [5]=1, [4:0]=imm[4:0]. Range −16..15.
  - ADD/AND, register mode: [5:3]=0, [2:0]=sr2. No check.
  - BR/LEA: [11:9]=dr, [8:0]=imm[9:1]. Must be even, −512..510.
  - JSR: [11]=1, [10:0]=imm[11:1]. Must be even, −2048..2046.
  - JSRR: [11:9]=0, [8:6]=sr1, [5:0]=0.
  - LDR/STR/LDI/STI: [11:9]=dr, [8:6]=sr1, [5:0]=imm[6:1]. Must be even, −64..62.
  - LDB/STB: [5:0]=imm[5:0]. Range −32..31.
  - TRAP: [11:8]=0, [7:0]=imm[8:1]. Must be even, 0..510.
  - SHF: [11:9]=dr, [8:6]=sr1, [5:4]=in_shf, [3:0]=imm[3:0]. Range 0..15.
  - NOT: [11:9]=dr, [8:6]=sr1, [5:0]=6'h3F.
  - JMP: [11:9]=0, [8:6]=sr1, [5:0]=0.
  - RTI: 16'h8000.
- Signed range check: imm[15:N−1] all equal, where N is the signed byte-offset width. Unsigned range check: imm[15:N] all zero.
- On error, the stored word is 16'h0000, err=1, and err_cnt increments (saturating).
- Address counter: each accepted request takes the current value, then the counter advances by 2 (16-bit wrap, 16'hFFFE → 16'h0000).
- addr_load has priority. A request accepted in the same cycle as addr_load is tagged with addr_base, and the counter becomes addr_base+2.
- FIFO: 2 entries, strict order. Push on accept, pop on out handshake. Push and pop in the same cycle keep the count unchanged.
- Reset values: FIFO empty, out_valid=0, in_ready=1, out_instr/out_addr/out_err=0, counter=RESET_ADDR, enc_cnt=0, err_cnt=0.
- Reset asserted mid-operation discards all FIFO contents immediately (asynchronous). No partial output.

## Timing
- Latency 1: a request accepted at edge k is visible at out_* after edge k when the FIFO was empty.
- in_ready is registered: in_ready = (count < 2). With 2 entries and a pop at the same edge, in_ready rises only after that edge. Full throughput is sustained at count ≤ 1.
- Outputs are driven directly from the FIFO head register, with no combinational path from in_* to out_*.
- in_ready does not depend combinationally on out_ready.

## Structure
- lc3b_types: lc3b_opcode enum (if not already present), plus packed struct lc3b_enc_req_t {opcode, dr, sr1, sr2, imm_sel, shf, imm} and lc3b_enc_entry_t {instr, addr, err}.
- Sub-module lc3b_encode_fields: purely combinational, lc3b_enc_req_t → {instr, err}. The top level holds the FIFO, the address counter and the statistics counters.

## Test plan
- ADD opcode 0001, dr=1, sr1=2, imm_sel=1, imm=16'hFFFD → out_instr 16'h12BD, err=0, out_addr 16'h0000, one cycle after accept.
- BR dr=3'b111, imm=16'hFFFC → 16'h0FFE. TRAP imm=16'h0046 → 16'hF023, addr 16'h0002.
- LDR imm=16'h0005 (odd) → out_instr 16'h0000, err=1, err_cnt=1. ADD imm mode with imm=16'h0010 → err=1, err_cnt=2.
- out_ready=0, three back-to-back requests → first two accepted, in_ready=0 after the second. Release out_ready → words popped in order with addrs 0,2; the third is accepted the cycle after the first pop and gets addr 4.
- addr_load=1, addr_base=16'hFFFE, with a request in the same cycle → tag 16'hFFFE; the next request gets 16'h0000.
- Two entries queued and enc_cnt=2, then pulse rst_n low asynchronously → out_valid=0 and enc_cnt=0 before the next edge; in_ready=1 once released.
